// File: rtl/state_dec_pkg.sv
// -----------------------------------------------------------------------------
// state_dec_pkg
// Shared constants and types for the state_decider block: lane counts, the
// 3-bit congestion level type, the packed 12-bit per-intersection state
// vector and the FSM state enumeration.
// -----------------------------------------------------------------------------
package state_dec_pkg;

  localparam int LANES    = 4;              // lanes per intersection
  localparam int LVL_W    = 3;              // bits per congestion level
  localparam int NUM_INT  = 2;              // intersections A and B
  localparam int VEC_W    = LANES * LVL_W;  // packed state width (12)
  localparam int TOT_LANE = LANES * NUM_INT;

  typedef logic [LVL_W-1:0] lvl_t;
  typedef logic [VEC_W-1:0] state_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUANT = 2'd1,
    DONE  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/lane_queue_counter.sv
// -----------------------------------------------------------------------------
// lane_queue_counter
// Saturating up/down queue-length counter for one lane.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset, clears the count
//   arr_i  : vehicle-arrival pulse (+1)
//   dep_i  : vehicle-departure pulse (-1)
//   cnt_o  : current registered count
//   sat_o  : combinational event, high in a cycle where an arrival hits the
//            maximum count or a departure hits zero (count holds)
// Simultaneous arrival and departure leave the count unchanged.
// -----------------------------------------------------------------------------
module lane_queue_counter
  import state_dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arr_i,
  input  logic             dep_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_o = 1'b0;
    if (arr_i && !dep_i) begin
      if (cnt_q == CNT_MAX) sat_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dep_i && !arr_i) begin
      if (cnt_q == '0) sat_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/state_decider.sv
// -----------------------------------------------------------------------------
// state_decider
// Tracks queue lengths for the 4 lanes of intersections A and B, and on
// request snapshots all 8 counts and quantises them (one lane per cycle
// through a shared quantiser) into 3-bit congestion levels.
//   clk          : system clock
//   rst          : synchronous active-high reset; aborts any quantisation
//   arr_A/dep_A  : per-lane arrival/departure pulses, intersection A
//   arr_B/dep_B  : per-lane arrival/departure pulses, intersection B
//   sample_req   : start a new quantisation; only taken in IDLE
//   busy         : high during the 8 quantisation cycles
//   state_valid  : one-cycle strobe, S_A/S_B were just updated
//   S_A/S_B      : packed levels, lane i in bits [3i+2:3i]
//   sat_flag     : sticky counter saturation/underflow indicator
// Handshake: sample_req is a request sampled on a clock edge while the FSM
// is IDLE; requests in any other state are dropped, never queued. The
// result is announced by state_valid for exactly one cycle; there is no
// back-pressure from the consumer.
// Optional build macro STATE_DEC_HYST_EN: published levels may rise at once
// but only drop after two consecutive lower computed levels.
// -----------------------------------------------------------------------------
module state_decider
  import state_dec_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int LVL_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] arr_A,
  input  logic [LANES-1:0] dep_A,
  input  logic [LANES-1:0] arr_B,
  input  logic [LANES-1:0] dep_B,
  input  logic             sample_req,
  output logic             busy,
  output logic             state_valid,
  output state_vec_t       S_A,
  output state_vec_t       S_B,
  output logic             sat_flag
);

  localparam int IDX_W = $clog2(TOT_LANE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_LANE - 1);

  // Lane index 0-3 are A lanes, 4-7 are B lanes.
  logic [TOT_LANE-1:0] arr_all, dep_all, sat_ev;
  logic [CNT_W-1:0]    cnt [TOT_LANE];

  assign arr_all = {arr_B, arr_A};
  assign dep_all = {dep_B, dep_A};

  for (genvar g = 0; g < TOT_LANE; g++) begin : g_lane
    lane_queue_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .arr_i (arr_all[g]),
      .dep_i (dep_all[g]),
      .cnt_o (cnt[g]),
      .sat_o (sat_ev[g])
    );
  end

  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst)          sat_q <= 1'b0;
    else if (|sat_ev) sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;

  // FSM and datapath registers
  fsm_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       snap_q [TOT_LANE];
  logic [2*VEC_W-1:0]     shadow_q, shadow_d;
  state_vec_t             s_a_q, s_b_q;
  logic                   busy_q, valid_q;

  // Shared quantiser on the lane selected by idx_q
  logic [CNT_W-1:0] cur_cnt, cur_shift;
  lvl_t             calc_lvl, new_lvl;

`ifdef STATE_DEC_HYST_EN
  logic [TOT_LANE-1:0] pend_q, pend_d;
  logic [2*VEC_W-1:0]  pub_vec;
  lvl_t                pub_lvl;
  assign pub_vec = {s_b_q, s_a_q};
`endif

  always_comb begin
    cur_cnt   = snap_q[idx_q];
    cur_shift = cur_cnt >> LVL_SHIFT;
    calc_lvl  = (cur_shift > CNT_W'(7)) ? lvl_t'(7) : cur_shift[LVL_W-1:0];
    new_lvl   = calc_lvl;
`ifdef STATE_DEC_HYST_EN
    // Published output is stable during QUANT, so it is the reference level.
    pend_d  = pend_q;
    pub_lvl = pub_vec[idx_q*LVL_W +: LVL_W];
    if (calc_lvl >= pub_lvl) begin
      pend_d[idx_q] = 1'b0;
    end else if (pend_q[idx_q]) begin
      pend_d[idx_q] = 1'b0;               // second lower sample: accept drop
    end else begin
      new_lvl       = pub_lvl;            // first lower sample: hold
      pend_d[idx_q] = 1'b1;
    end
`endif
    shadow_d = shadow_q;
    shadow_d[idx_q*LVL_W +: LVL_W] = new_lvl;
  end

  // Outputs are published on the edge that finishes the last lane, so they
  // and state_valid are visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      s_a_q    <= '0;
      s_b_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < TOT_LANE; i++) snap_q[i] <= '0;
`ifdef STATE_DEC_HYST_EN
      pend_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (sample_req) begin
            for (int i = 0; i < TOT_LANE; i++) snap_q[i] <= cnt[i];
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= QUANT;
          end
        end
        QUANT: begin
          shadow_q <= shadow_d;
`ifdef STATE_DEC_HYST_EN
          pend_q   <= pend_d;
`endif
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            s_a_q   <= shadow_d[VEC_W-1:0];
            s_b_q   <= shadow_d[2*VEC_W-1:VEC_W];
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign state_valid = valid_q;
  assign S_A         = s_a_q;
  assign S_B         = s_b_q;

endmodule
